// File: rtl/fpu_arbiter_seq.sv
// Round-robin arbiter that shares one FPU between two requesters, holds operands for
// the whole operation and returns one tagged result per accepted request.
module fpu_arbiter_seq #(
    parameter int ADD_LAT     = 2,
    parameter int MUL_LAT     = 1,
    parameter int DIV_MIN     = 2,
    parameter int DIV_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        r0_valid,
    output logic        r0_ready,
    input  logic [1:0]  r0_funct,
    input  logic [31:0] r0_a,
    input  logic [31:0] r0_b,
    input  logic        r1_valid,
    output logic        r1_ready,
    input  logic [1:0]  r1_funct,
    input  logic [31:0] r1_a,
    input  logic [31:0] r1_b,
    output logic [1:0]  fpu_funct,
    output logic [31:0] fpu_a,
    output logic [31:0] fpu_b,
    input  logic [31:0] fpu_o,
    input  logic        fpu_div_fin,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic        resp_id,
    output logic [31:0] resp_data,
    output logic        resp_timeout
);

    localparam int LAT_MAX = (ADD_LAT > MUL_LAT) ? ADD_LAT : MUL_LAT;
    localparam int CW      = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;
    localparam int WW      = (DIV_TIMEOUT > 1) ? $clog2(DIV_TIMEOUT) : 1;

    localparam logic [CW-1:0] ADD_LOAD   = CW'(ADD_LAT - 1);
    localparam logic [CW-1:0] MUL_LOAD   = CW'(MUL_LAT - 1);
    localparam logic [WW-1:0] WCNT_MIN   = WW'(DIV_MIN);
    localparam logic [WW-1:0] WCNT_LAST  = WW'(DIV_TIMEOUT - 1);
    localparam logic [31:0]   QNAN       = 32'h7FC0_0000;
    localparam logic [1:0]    FUNCT_DIV  = 2'd2;
    localparam logic [1:0]    FUNCT_MUL  = 2'd3;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]    state_q, state_d;
    logic          last_grant_q, last_grant_d;
    logic [1:0]    funct_q, funct_d;
    logic [31:0]   a_q, a_d;
    logic [31:0]   b_q, b_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [WW-1:0] wcnt_q, wcnt_d;
    logic          resp_id_q, resp_id_d;
    logic [31:0]   resp_data_q, resp_data_d;
    logic          resp_timeout_q, resp_timeout_d;

    logic          grant_id;
    logic          accept;
    logic [1:0]    sel_funct;
    logic [31:0]   sel_a;
    logic [31:0]   sel_b;
    logic          fin_ok;

    // With both requesting, the one that did not win last time goes next.
    always_comb begin
        grant_id = 1'b0;
        if (r0_valid && r1_valid) begin
            grant_id = ~last_grant_q;
        end else if (r1_valid) begin
            grant_id = 1'b1;
        end
    end

    // Gated by rst_n so a requester sees no ready while reset is held.
    assign r0_ready = rst_n && (state_q == IDLE) && r0_valid && !grant_id;
    assign r1_ready = rst_n && (state_q == IDLE) && r1_valid &&  grant_id;
    assign accept   = r0_ready || r1_ready;

    assign sel_funct = grant_id ? r1_funct : r0_funct;
    assign sel_a     = grant_id ? r1_a     : r0_a;
    assign sel_b     = grant_id ? r1_b     : r0_b;

    // Finish flag may be stale from a previous divide during the first DIV_MIN cycles.
    assign fin_ok = (wcnt_q >= WCNT_MIN) && fpu_div_fin;

    always_comb begin
        state_d        = state_q;
        last_grant_d   = last_grant_q;
        funct_d        = funct_q;
        a_d            = a_q;
        b_d            = b_q;
        cnt_d          = cnt_q;
        wcnt_d         = wcnt_q;
        resp_id_d      = resp_id_q;
        resp_data_d    = resp_data_q;
        resp_timeout_d = resp_timeout_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    funct_d      = sel_funct;
                    a_d          = sel_a;
                    b_d          = sel_b;
                    resp_id_d    = grant_id;
                    last_grant_d = grant_id;
                    wcnt_d       = '0;
                    if (sel_funct == FUNCT_DIV) begin
                        cnt_d = '0;
                    end else if (sel_funct == FUNCT_MUL) begin
                        cnt_d = MUL_LOAD;
                    end else begin
                        cnt_d = ADD_LOAD;
                    end
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (funct_q == FUNCT_DIV) begin
                    if (fin_ok) begin
                        resp_data_d    = fpu_o;
                        resp_timeout_d = 1'b0;
                        state_d        = RESP;
                    end else if (wcnt_q == WCNT_LAST) begin
                        resp_data_d    = QNAN;
                        resp_timeout_d = 1'b1;
                        state_d        = RESP;
                    end else begin
                        wcnt_d = wcnt_q + WW'(1);
                    end
                end else if (cnt_q == '0) begin
                    resp_data_d    = fpu_o;
                    resp_timeout_d = 1'b0;
                    state_d        = RESP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            last_grant_q   <= 1'b1;
            funct_q        <= '0;
            a_q            <= '0;
            b_q            <= '0;
            cnt_q          <= '0;
            wcnt_q         <= '0;
            resp_id_q      <= 1'b0;
            resp_data_q    <= '0;
            resp_timeout_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            last_grant_q   <= last_grant_d;
            funct_q        <= funct_d;
            a_q            <= a_d;
            b_q            <= b_d;
            cnt_q          <= cnt_d;
            wcnt_q         <= wcnt_d;
            resp_id_q      <= resp_id_d;
            resp_data_q    <= resp_data_d;
            resp_timeout_q <= resp_timeout_d;
        end
    end

    assign fpu_funct    = funct_q;
    assign fpu_a        = a_q;
    assign fpu_b        = b_q;
    assign resp_valid   = (state_q == RESP);
    assign resp_id      = resp_id_q;
    assign resp_data    = resp_data_q;
    assign resp_timeout = resp_timeout_q;

endmodule

// File: tb/tb_fpu_arbiter_seq.sv
// Directed bench for fpu_arbiter_seq: reset, add latency, divide stale-fin and timeout,
// round-robin contention, backpressure and mid-operation reset.
module tb_fpu_arbiter_seq;

    logic        clk;
    logic        rst_n;
    logic        r0_valid, r0_ready;
    logic [1:0]  r0_funct;
    logic [31:0] r0_a, r0_b;
    logic        r1_valid, r1_ready;
    logic [1:0]  r1_funct;
    logic [31:0] r1_a, r1_b;
    logic [1:0]  fpu_funct;
    logic [31:0] fpu_a, fpu_b, fpu_o;
    logic        fpu_div_fin;
    logic        resp_valid, resp_ready, resp_id, resp_timeout;
    logic [31:0] resp_data;

    int errorCount = 0;
    int checkCount = 0;

    fpu_arbiter_seq dut (
        .clk(clk), .rst_n(rst_n),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_funct(r0_funct), .r0_a(r0_a), .r0_b(r0_b),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_funct(r1_funct), .r1_a(r1_a), .r1_b(r1_b),
        .fpu_funct(fpu_funct), .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_o(fpu_o),
        .fpu_div_fin(fpu_div_fin),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_data(resp_data), .resp_timeout(resp_timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got no finish expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input int id, input logic v, input logic [1:0] f,
                                 input logic [31:0] a, input logic [31:0] b);
        if (id == 0) begin
            r0_valid = v; r0_funct = f; r0_a = a; r0_b = b;
        end else begin
            r1_valid = v; r1_funct = f; r1_a = a; r1_b = b;
        end
    endtask

    // Issues one request, waits for the grant, and returns cycles from accept to resp_valid.
    task automatic runOp(input int id, input logic [1:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic finHeld, input int finAt,
                         output int lat);
        int w;
        int k;
        logic got;
        lat = -1;
        got = 1'b0;
        applyStimulus(id, 1'b1, f, a, b);
        fpu_div_fin = finHeld;
        #1;
        w = 0;
        while (!got && w < 10) begin
            if ((id == 0) ? r0_ready : r1_ready) begin
                got = 1'b1;
            end else begin
                @(posedge clk); #2;
                w++;
            end
        end
        checkOutput("accept", 64'(got), 64'(1));
        if (!got) begin
            applyStimulus(id, 1'b0, f, a, b);
            return;
        end
        k = 1;
        while (lat < 0 && k <= 200) begin
            @(posedge clk); #1;
            if (k == 1) applyStimulus(id, 1'b0, f, a, b);
            fpu_div_fin = finHeld || (k == finAt);
            #1;
            if (resp_valid) lat = k;
            k++;
        end
        fpu_div_fin = 1'b0;
    endtask

    task automatic respAccept();
        @(posedge clk); #1;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        #1;
        checkOutput("resp_drop", 64'(resp_valid), 64'(0));
    endtask

    initial begin
        int lat;
        int nG, nR, both, readyInResp, dataBad, c;
        logic [3:0] gv, iv;

        rst_n = 1'b0;
        applyStimulus(0, 1'b1, 2'd0, 32'h3F80_0000, 32'h4000_0000);
        applyStimulus(1, 1'b0, 2'd0, 32'h0, 32'h0);
        fpu_o = 32'h4040_0000;
        fpu_div_fin = 1'b0;
        resp_ready = 1'b0;

        // T1 reset
        repeat (2) @(posedge clk);
        #2;
        checkOutput("rst_ready", 64'({r1_ready, r0_ready}), 64'(0));
        checkOutput("rst_resp", 64'({resp_valid, resp_id, resp_timeout}), 64'(0));
        checkOutput("rst_data", 64'(resp_data), 64'(0));
        checkOutput("rst_fpu_a", 64'(fpu_a), 64'(0));
        checkOutput("rst_fpu_b", 64'(fpu_b), 64'(0));
        checkOutput("rst_fpu_funct", 64'(fpu_funct), 64'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        checkOutput("post_rst_ready", 64'(r0_ready), 64'(1));

        // T2 add
        runOp(0, 2'd0, 32'h3F80_0000, 32'h4000_0000, 1'b0, -1, lat);
        checkOutput("add_lat", 64'(lat), 64'(3));
        checkOutput("add_data", 64'(resp_data), 64'h4040_0000);
        checkOutput("add_id", 64'(resp_id), 64'(0));
        checkOutput("add_timeout", 64'(resp_timeout), 64'(0));
        checkOutput("add_fpu_a", 64'(fpu_a), 64'h3F80_0000);
        checkOutput("add_fpu_b", 64'(fpu_b), 64'h4000_0000);
        checkOutput("add_fpu_funct", 64'(fpu_funct), 64'(0));
        respAccept();

        // T4 divide: stale fin held, then a late fin pulse at EXEC cycle 10
        fpu_o = 32'h3F00_0000;
        runOp(1, 2'd2, 32'h3F80_0000, 32'h4000_0000, 1'b1, 11, lat);
        checkOutput("div_stale_lat", 64'(lat), 64'(4));
        checkOutput("div_stale_data", 64'(resp_data), 64'h3F00_0000);
        checkOutput("div_stale_id", 64'(resp_id), 64'(1));
        checkOutput("div_stale_timeout", 64'(resp_timeout), 64'(0));
        respAccept();
        fpu_o = 32'h3E80_0000;
        runOp(1, 2'd2, 32'h3F80_0000, 32'h4080_0000, 1'b0, 11, lat);
        checkOutput("div_late_lat", 64'(lat), 64'(12));
        checkOutput("div_late_data", 64'(resp_data), 64'h3E80_0000);
        checkOutput("div_late_id", 64'(resp_id), 64'(1));
        respAccept();

        // T3 contention: r1 won last, so r0 goes first
        fpu_o = 32'h40C0_0000;
        @(posedge clk); #1;
        applyStimulus(0, 1'b1, 2'd3, 32'h4040_0000, 32'h4000_0000);
        applyStimulus(1, 1'b1, 2'd3, 32'h4040_0000, 32'h4000_0000);
        resp_ready = 1'b1;
        #1;
        nG = 0; nR = 0; both = 0; readyInResp = 0; dataBad = 0; c = 0;
        gv = '0; iv = '0;
        while (nR < 4 && c < 60) begin
            if (r0_ready && r1_ready) both++;
            if (r0_ready || r1_ready) begin
                if (r1_ready && nG < 4) gv = gv | (4'(1) << nG);
                nG++;
            end
            if (resp_valid) begin
                if (resp_id) iv = iv | (4'(1) << nR);
                if (resp_data !== 32'h40C0_0000) dataBad++;
                if (r0_ready || r1_ready) readyInResp++;
                nR++;
            end
            c++;
            if (nR < 4) begin
                @(posedge clk); #2;
            end
        end
        @(posedge clk); #1;
        applyStimulus(0, 1'b0, 2'd3, 32'h4040_0000, 32'h4000_0000);
        applyStimulus(1, 1'b0, 2'd3, 32'h4040_0000, 32'h4000_0000);
        resp_ready = 1'b0;
        #1;
        checkOutput("rr_resp_count", 64'(nR), 64'(4));
        checkOutput("rr_grant_count", 64'(nG), 64'(4));
        checkOutput("rr_grant_order", 64'(gv), 64'(4'b1010));
        checkOutput("rr_resp_ids", 64'(iv), 64'(4'b1010));
        checkOutput("rr_both_ready", 64'(both), 64'(0));
        checkOutput("rr_ready_in_resp", 64'(readyInResp), 64'(0));
        checkOutput("rr_data", 64'(dataBad), 64'(0));
        checkOutput("rr_idle_after", 64'(resp_valid), 64'(0));

        // T5 divide timeout, then a normal request
        runOp(0, 2'd2, 32'h3F80_0000, 32'h0000_0000, 1'b0, -1, lat);
        checkOutput("to_lat", 64'(lat), 64'(65));
        checkOutput("to_data", 64'(resp_data), 64'h7FC0_0000);
        checkOutput("to_flag", 64'(resp_timeout), 64'(1));
        checkOutput("to_id", 64'(resp_id), 64'(0));
        respAccept();
        fpu_o = 32'h4040_0000;
        runOp(0, 2'd0, 32'h3F80_0000, 32'h4000_0000, 1'b0, -1, lat);
        checkOutput("after_to_lat", 64'(lat), 64'(3));
        checkOutput("after_to_data", 64'(resp_data), 64'h4040_0000);
        checkOutput("after_to_flag", 64'(resp_timeout), 64'(0));
        respAccept();

        // T6 backpressure with a competing request pending and a changing fpu_o
        fpu_o = 32'h40C0_0000;
        runOp(1, 2'd3, 32'h4040_0000, 32'h4000_0000, 1'b0, -1, lat);
        checkOutput("mul_lat", 64'(lat), 64'(2));
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (i == 0) begin
                applyStimulus(0, 1'b1, 2'd2, 32'h3F80_0000, 32'h4000_0000);
                fpu_o = 32'h1234_5678;
            end
            #1;
            checkOutput("bp_hold",
                64'({resp_valid, resp_id, resp_timeout, r1_ready, r0_ready, resp_data}),
                64'({1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h40C0_0000}));
        end
        @(posedge clk); #1;
        resp_ready = 1'b1;
        #1;
        checkOutput("hs_no_grant", 64'({resp_valid, r0_ready}), 64'(2'b10));
        @(posedge clk); #1;
        resp_ready = 1'b0;
        #1;
        checkOutput("grant_after_hs", 64'({resp_valid, r0_ready}), 64'(2'b01));
        @(posedge clk); #1;
        applyStimulus(0, 1'b0, 2'd2, 32'h3F80_0000, 32'h4000_0000);
        #1;
        checkOutput("div_latched", 64'({fpu_funct, fpu_a}), 64'({2'd2, 32'h3F80_0000}));
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("abort_resp", 64'({resp_valid, resp_timeout}), 64'(0));
        checkOutput("abort_ops", 64'({fpu_funct, fpu_a}), 64'(0));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        checkOutput("abort_idle", 64'(resp_valid), 64'(0));
        fpu_o = 32'h4040_0000;
        runOp(1, 2'd0, 32'h3F80_0000, 32'h4000_0000, 1'b0, -1, lat);
        checkOutput("restart_lat", 64'(lat), 64'(3));
        checkOutput("restart_data", 64'(resp_data), 64'h4040_0000);
        checkOutput("restart_id", 64'(resp_id), 64'(1));
        respAccept();

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
